// File: rtl/rf_row_sequencer.sv
// Per-row in-order access sequencer in front of the matrix register file.
// Each (register,row) holds a head token register plus a (DEPTH-1)-entry FIFO,
// so a row stores up to DEPTH tokens and a push into an idle row is at the head next cycle.
module rf_row_sequencer #(
  parameter int N_REGS         = 8,
  parameter int N_ROWS         = 4,
  parameter int RLEN           = 128,
  parameter int READ_PORTS     = 4,
  parameter int WRITE_PORTS    = 2,
  parameter int RF_READ_PORTS  = 3,
  parameter int RF_WRITE_PORTS = 1,
  parameter int DEPTH          = 4,
  parameter int ID_W           = 4,
  parameter int MAX_RD         = 3,
  localparam int NRD_W         = $clog2(MAX_RD + 1),
  localparam int RA            = (N_REGS > 1) ? $clog2(N_REGS) : 1,
  localparam int RR            = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
  localparam int HW            = 1 + ID_W + 1 + NRD_W
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic [N_REGS-1:0]                push_i,
  input  logic [N_REGS*N_ROWS-1:0]         push_rowmask_i,
  input  logic [N_REGS*ID_W-1:0]           push_id_i,
  input  logic [N_REGS-1:0]                push_wr_i,
  input  logic [N_REGS*NRD_W-1:0]          push_nrd_i,
  output logic [N_REGS-1:0]                full_o,
  output logic                             overflow_o,
  output logic                             busy_o,
  input  logic [READ_PORTS-1:0]            rreq_i,
  input  logic [READ_PORTS*ID_W-1:0]       rd_id_i,
  input  logic [READ_PORTS*RA-1:0]         raddr_i,
  input  logic [READ_PORTS*RR-1:0]         rrowaddr_i,
  output logic [READ_PORTS-1:0]            rvalid_o,
  output logic [READ_PORTS*RLEN-1:0]       rdata_o,
  input  logic [WRITE_PORTS-1:0]           wreq_i,
  input  logic [WRITE_PORTS*ID_W-1:0]      wr_id_i,
  input  logic [WRITE_PORTS*RA-1:0]        waddr_i,
  input  logic [WRITE_PORTS*RR-1:0]        wrowaddr_i,
  input  logic [WRITE_PORTS*RLEN-1:0]      wdata_i,
  output logic [WRITE_PORTS-1:0]           wready_o,
  output logic [RF_READ_PORTS*RA-1:0]      rf_raddr_o,
  output logic [RF_READ_PORTS*RR-1:0]      rf_rrow_o,
  input  logic [RF_READ_PORTS*RLEN-1:0]    rf_rdata_i,
  output logic [RF_WRITE_PORTS-1:0]        rf_we_o,
  output logic [RF_WRITE_PORTS*RA-1:0]     rf_waddr_o,
  output logic [RF_WRITE_PORTS*RR-1:0]     rf_wrow_o,
  output logic [RF_WRITE_PORTS*RLEN-1:0]   rf_wdata_o,
  output logic [N_REGS*N_ROWS*HW-1:0]      head_o
);

  localparam int NH  = N_REGS * N_ROWS;
  localparam int HA  = (NH > 1) ? $clog2(NH) : 1;
  localparam int TW  = ID_W + 1 + NRD_W;
  localparam int CW  = $clog2(DEPTH);
  localparam int RPW = (READ_PORTS > 1) ? $clog2(READ_PORTS) : 1;
  localparam int WPW = (WRITE_PORTS > 1) ? $clog2(WRITE_PORTS) : 1;

  logic [NH-1:0]    head_v, head_wr;
  logic [ID_W-1:0]  head_id  [NH];
  logic [NRD_W-1:0] head_nrd [NH];
  logic [TW-1:0]    fifo     [NH][DEPTH-1];
  logic [CW-1:0]    cnt      [NH];
  logic             overflow;
  logic [RPW-1:0]   rptr, rptr_next;
  logic [WPW-1:0]   wptr, wptr_next;

  logic [READ_PORTS-1:0]  rcand, relig, rgrant;
  logic [WRITE_PORTS-1:0] wcand, welig, wgrant;
  logic [HA-1:0]          rtgt [READ_PORTS];
  logic [HA-1:0]          wtgt [WRITE_PORTS];
  logic [NH-1:0]          rd_hit, wr_hit, wr_next, retire, full, push_ok, push_drop;
  logic [NRD_W-1:0]       nrd_next [NH];
  logic [TW-1:0]          push_tok [NH];

  // Per-port eligibility against the addressed head; only the lowest port may hit a given head
  always_comb begin
    int unsigned t;
    rcand = '0;
    wcand = '0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      t = 32'(raddr_i[p*RA +: RA]) * N_ROWS + 32'(rrowaddr_i[p*RR +: RR]);
      rtgt[p] = HA'(t);
      if (t < NH)
        rcand[p] = rreq_i[p] && head_v[rtgt[p]] && head_id[rtgt[p]] == rd_id_i[p*ID_W +: ID_W]
                   && head_nrd[rtgt[p]] != '0 && !flush_i && !rst_i;
    end
    for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
      t = 32'(waddr_i[p*RA +: RA]) * N_ROWS + 32'(wrowaddr_i[p*RR +: RR]);
      wtgt[p] = HA'(t);
      if (t < NH)
        wcand[p] = wreq_i[p] && head_v[wtgt[p]] && head_id[wtgt[p]] == wr_id_i[p*ID_W +: ID_W]
                   && head_wr[wtgt[p]] && head_nrd[wtgt[p]] == '0 && !flush_i && !rst_i;
    end
    relig = rcand;
    for (int unsigned p = 1; p < READ_PORTS; p++)
      for (int unsigned q = 0; q < p; q++)
        if (rcand[q] && rtgt[q] == rtgt[p]) relig[p] = 1'b0;
    welig = wcand;
    for (int unsigned p = 1; p < WRITE_PORTS; p++)
      for (int unsigned q = 0; q < p; q++)
        if (wcand[q] && wtgt[q] == wtgt[p]) welig[p] = 1'b0;
  end

  // Round-robin arbitration per class, granting up to the number of physical RF ports
  always_comb begin
    int unsigned idx, n;
    logic [RPW-1:0] ri;
    logic [WPW-1:0] wi;
    rgrant = '0;
    wgrant = '0;
    rptr_next = rptr;
    wptr_next = wptr;
    if (RF_READ_PORTS >= READ_PORTS) begin
      rgrant = relig;
    end else begin
      n = 0;
      for (int unsigned i = 0; i < READ_PORTS; i++) begin
        idx = 32'(rptr) + i;
        if (idx >= READ_PORTS) idx = idx - READ_PORTS;
        ri = RPW'(idx);
        if (relig[ri] && n < RF_READ_PORTS) begin
          rgrant[ri] = 1'b1;
          n = n + 1;
          rptr_next = (idx + 1 >= READ_PORTS) ? '0 : RPW'(idx + 1);
        end
      end
    end
    if (RF_WRITE_PORTS >= WRITE_PORTS) begin
      wgrant = welig;
    end else begin
      n = 0;
      for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
        idx = 32'(wptr) + i;
        if (idx >= WRITE_PORTS) idx = idx - WRITE_PORTS;
        wi = WPW'(idx);
        if (welig[wi] && n < RF_WRITE_PORTS) begin
          wgrant[wi] = 1'b1;
          n = n + 1;
          wptr_next = (idx + 1 >= WRITE_PORTS) ? '0 : WPW'(idx + 1);
        end
      end
    end
  end

  // Map granted FU ports onto RF ports in ascending port order; rdata returns combinationally
  always_comb begin
    int unsigned k;
    rvalid_o   = rgrant;
    wready_o   = wgrant;
    rdata_o    = '0;
    rf_raddr_o = '0;
    rf_rrow_o  = '0;
    rf_we_o    = '0;
    rf_waddr_o = '0;
    rf_wrow_o  = '0;
    rf_wdata_o = '0;
    k = 0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      if (rgrant[p] && k < RF_READ_PORTS) begin
        rf_raddr_o[k*RA +: RA]     = raddr_i[p*RA +: RA];
        rf_rrow_o[k*RR +: RR]      = rrowaddr_i[p*RR +: RR];
        rdata_o[p*RLEN +: RLEN]    = rf_rdata_i[k*RLEN +: RLEN];
        k = k + 1;
      end
    end
    k = 0;
    for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
      if (wgrant[p] && k < RF_WRITE_PORTS) begin
        rf_we_o[k]                 = 1'b1;
        rf_waddr_o[k*RA +: RA]     = waddr_i[p*RA +: RA];
        rf_wrow_o[k*RR +: RR]      = wrowaddr_i[p*RR +: RR];
        rf_wdata_o[k*RLEN +: RLEN] = wdata_i[p*RLEN +: RLEN];
        k = k + 1;
      end
    end
  end

  // Head update, retire detection, push acceptance and status flags per row
  always_comb begin
    int unsigned r;
    logic want;
    rd_hit = '0;
    wr_hit = '0;
    full_o = '0;
    busy_o = 1'b0;
    head_o = '0;
    for (int unsigned p = 0; p < READ_PORTS; p++)
      if (rgrant[p]) rd_hit[rtgt[p]] = 1'b1;
    for (int unsigned p = 0; p < WRITE_PORTS; p++)
      if (wgrant[p]) wr_hit[wtgt[p]] = 1'b1;
    for (int unsigned h = 0; h < NH; h++) begin
      r = h / N_ROWS;
      push_tok[h] = {push_id_i[r*ID_W +: ID_W], push_wr_i[r], push_nrd_i[r*NRD_W +: NRD_W]};
      nrd_next[h] = head_nrd[h] - NRD_W'(rd_hit[h]);
      wr_next[h]  = head_wr[h] & ~wr_hit[h];
      retire[h]   = head_v[h] && !wr_next[h] && nrd_next[h] == '0;
      full[h]     = head_v[h] && cnt[h] == CW'(DEPTH - 1);
      want        = !flush_i && push_i[r] && push_rowmask_i[h]
                    && (push_wr_i[r] || push_nrd_i[r*NRD_W +: NRD_W] != '0);
      // a retiring head frees a slot in the same cycle, so a full row still accepts
      push_ok[h]   = want && (!full[h] || retire[h]);
      push_drop[h] = want && full[h] && !retire[h];
      full_o[r]    = full_o[r] | full[h];
      busy_o       = busy_o | head_v[h] | (cnt[h] != '0);
      head_o[h*HW +: HW] = {head_v[h], head_id[h], head_wr[h], head_nrd[h]};
    end
  end

  assign overflow_o = overflow;

  // Row storage: head register plus shift FIFO; an idle row takes a push straight into the head
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_v  <= '0;
      head_wr <= '0;
      for (int unsigned h = 0; h < NH; h++) begin
        head_id[h]  <= '0;
        head_nrd[h] <= '0;
        cnt[h]      <= '0;
        for (int unsigned e = 0; e < DEPTH - 1; e++) fifo[h][e] <= '0;
      end
    end else if (flush_i) begin
      head_v  <= '0;
      head_wr <= '0;
      for (int unsigned h = 0; h < NH; h++) cnt[h] <= '0;
    end else begin
      for (int unsigned h = 0; h < NH; h++) begin
        if (head_v[h] && !retire[h]) begin
          head_nrd[h] <= nrd_next[h];
          head_wr[h]  <= wr_next[h];
          if (push_ok[h]) begin
            fifo[h][cnt[h]] <= push_tok[h];
            cnt[h]          <= cnt[h] + CW'(1);
          end
        end else if (cnt[h] != '0) begin
          {head_id[h], head_wr[h], head_nrd[h]} <= fifo[h][0];
          head_v[h] <= 1'b1;
          for (int unsigned e = 0; e + 1 < DEPTH - 1; e++) fifo[h][e] <= fifo[h][e+1];
          if (push_ok[h]) fifo[h][cnt[h] - CW'(1)] <= push_tok[h];
          else            cnt[h] <= cnt[h] - CW'(1);
        end else if (push_ok[h]) begin
          {head_id[h], head_wr[h], head_nrd[h]} <= push_tok[h];
          head_v[h] <= 1'b1;
        end else begin
          head_v[h] <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow flag (cleared only by flush) and round-robin pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow <= 1'b0;
      rptr     <= '0;
      wptr     <= '0;
    end else begin
      if (flush_i)         overflow <= 1'b0;
      else if (|push_drop) overflow <= 1'b1;
      rptr <= rptr_next;
      wptr <= wptr_next;
    end
  end

endmodule

// File: tb/tb_rf_row_sequencer.sv
// Directed bench for rf_row_sequencer: table of single-read routing vectors plus
// hand-written multi-cycle sequences (WAR ordering, arbitration, overflow, flush, reset).
module tb_rf_row_sequencer;
  localparam int NR = 8, NW = 4, RL = 128, RP = 4, WP = 2, RFR = 3, RFW = 1;
  localparam int IDW = 4, NRDW = 2, RA = 3, RR = 2, HW = 8;

  logic clk = 1'b0;
  logic rst_i, flush_i;
  logic [NR-1:0] push_i, push_wr_i, full_o;
  logic [NR*NW-1:0] push_rowmask_i;
  logic [NR*IDW-1:0] push_id_i;
  logic [NR*NRDW-1:0] push_nrd_i;
  logic overflow_o, busy_o;
  logic [RP-1:0] rreq_i, rvalid_o;
  logic [RP*IDW-1:0] rd_id_i;
  logic [RP*RA-1:0] raddr_i;
  logic [RP*RR-1:0] rrowaddr_i;
  logic [RP*RL-1:0] rdata_o;
  logic [WP-1:0] wreq_i, wready_o;
  logic [WP*IDW-1:0] wr_id_i;
  logic [WP*RA-1:0] waddr_i;
  logic [WP*RR-1:0] wrowaddr_i;
  logic [WP*RL-1:0] wdata_i;
  logic [RFR*RA-1:0] rf_raddr_o;
  logic [RFR*RR-1:0] rf_rrow_o;
  logic [RFR*RL-1:0] rf_rdata_i;
  logic [RFW-1:0] rf_we_o;
  logic [RFW*RA-1:0] rf_waddr_o;
  logic [RFW*RR-1:0] rf_wrow_o;
  logic [RFW*RL-1:0] rf_wdata_o;
  logic [NR*NW*HW-1:0] head_o;

  int total = 0;
  int bad = 0;

  rf_row_sequencer #(.N_REGS(NR), .N_ROWS(NW), .RLEN(RL), .READ_PORTS(RP), .WRITE_PORTS(WP),
    .RF_READ_PORTS(RFR), .RF_WRITE_PORTS(RFW), .DEPTH(4), .ID_W(IDW), .MAX_RD(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .push_i(push_i), .push_rowmask_i(push_rowmask_i), .push_id_i(push_id_i),
    .push_wr_i(push_wr_i), .push_nrd_i(push_nrd_i),
    .full_o(full_o), .overflow_o(overflow_o), .busy_o(busy_o),
    .rreq_i(rreq_i), .rd_id_i(rd_id_i), .raddr_i(raddr_i), .rrowaddr_i(rrowaddr_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .wreq_i(wreq_i), .wr_id_i(wr_id_i), .waddr_i(waddr_i), .wrowaddr_i(wrowaddr_i),
    .wdata_i(wdata_i), .wready_o(wready_o),
    .rf_raddr_o(rf_raddr_o), .rf_rrow_o(rf_rrow_o), .rf_rdata_i(rf_rdata_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wrow_o(rf_wrow_o), .rf_wdata_o(rf_wdata_o),
    .head_o(head_o));

  always #5 clk = ~clk;

  // Register file contents: a fixed pattern per (register,row)
  function automatic logic [RL-1:0] pat(input logic [RA-1:0] a, input logic [RR-1:0] r);
    logic [31:0] w;
    w = 32'h5A00_0000 | (32'(a) << 8) | 32'(r);
    return {w, ~w, w ^ 32'h1234_5678, w + 32'd7};
  endfunction

  always_comb begin
    rf_rdata_i = '0;
    for (int k = 0; k < RFR; k++)
      rf_rdata_i[k*RL +: RL] = pat(rf_raddr_o[k*RA +: RA], rf_rrow_o[k*RR +: RR]);
  end

  function automatic logic [HW-1:0] hd(input int r, input int w);
    return head_o[(r*NW + w)*HW +: HW];
  endfunction

  task automatic chk(input string nm, input logic [RL-1:0] act, input logic [RL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    flush_i = 0; push_i = '0; push_rowmask_i = '0; push_id_i = '0; push_wr_i = '0; push_nrd_i = '0;
    rreq_i = '0; rd_id_i = '0; raddr_i = '0; rrowaddr_i = '0;
    wreq_i = '0; wr_id_i = '0; waddr_i = '0; wrowaddr_i = '0; wdata_i = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    clr();
  endtask

  task automatic do_push(input int r, input logic [3:0] m, input logic [3:0] id,
                         input logic wr, input logic [1:0] nrd);
    push_i[r] = 1'b1;
    push_rowmask_i[r*NW +: NW] = m;
    push_id_i[r*IDW +: IDW] = id;
    push_wr_i[r] = wr;
    push_nrd_i[r*NRDW +: NRDW] = nrd;
  endtask

  task automatic rd(input int p, input int r, input int row, input logic [3:0] id);
    rreq_i[p] = 1'b1;
    rd_id_i[p*IDW +: IDW] = id;
    raddr_i[p*RA +: RA] = 3'(r);
    rrowaddr_i[p*RR +: RR] = 2'(row);
  endtask

  task automatic wr(input int p, input int r, input int row, input logic [3:0] id,
                    input logic [RL-1:0] d);
    wreq_i[p] = 1'b1;
    wr_id_i[p*IDW +: IDW] = id;
    waddr_i[p*RA +: RA] = 3'(r);
    wrowaddr_i[p*RR +: RR] = 2'(row);
    wdata_i[p*RL +: RL] = d;
  endtask

  task automatic do_reset();
    tick(); rst_i = 1;
    tick(); rst_i = 0;
  endtask

  typedef struct {
    int r; int row; logic [3:0] tok_id; logic [3:0] req_id; int port; logic grant;
  } vec_t;
  vec_t vecs[6];

  logic [RL-1:0] d1, d2, d3;

  initial begin
    vecs[0] = '{0, 0, 4'd1,  4'd1,  0, 1'b1};
    vecs[1] = '{1, 3, 4'd4,  4'd4,  2, 1'b1};
    vecs[2] = '{2, 2, 4'd7,  4'd6,  1, 1'b0};
    vecs[3] = '{7, 1, 4'd15, 4'd15, 3, 1'b1};
    vecs[4] = '{5, 0, 4'd8,  4'd8,  1, 1'b1};
    vecs[5] = '{6, 2, 4'd2,  4'd3,  0, 1'b0};
    d1 = {4{32'hC0DE_0001}};
    d2 = {4{32'hBEEF_0002}};
    d3 = {4{32'hF00D_0003}};

    // reset state, with requests already asserted
    clr(); rst_i = 1; rreq_i = '1; wreq_i = '1;
    @(negedge clk); #1;
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_ovf", 128'(overflow_o), 128'(0));
    chk("rst_rvalid", 128'(rvalid_o), 128'(0));
    chk("rst_wready", 128'(wready_o), 128'(0));
    chk("rst_we", 128'(rf_we_o), 128'(0));
    chk("rst_head", 128'(head_o), 128'(0));
    tick(); rst_i = 0;

    // table: single token, single read request, routing of rdata
    for (int i = 0; i < 6; i++) begin
      tick(); flush_i = 1;
      tick(); do_push(vecs[i].r, 4'(1 << vecs[i].row), vecs[i].tok_id, 1'b0, 2'd1);
      tick(); rd(vecs[i].port, vecs[i].r, vecs[i].row, vecs[i].req_id);
      #1;
      chk($sformatf("vec%0d_rvalid", i), 128'(rvalid_o), 128'(4'(vecs[i].grant) << vecs[i].port));
      if (vecs[i].grant)
        chk($sformatf("vec%0d_rdata", i), rdata_o[vecs[i].port*RL +: RL],
            pat(3'(vecs[i].r), 2'(vecs[i].row)));
    end
    tick(); flush_i = 1;

    // single write token: granted at t+1, head empty at t+2
    tick(); do_push(1, 4'b0001, 4'd2, 1'b1, 2'd0);
    #1 chk("wr_head_t0", 128'(hd(1, 0) >> 7), 128'(0));
    tick(); wr(0, 1, 0, 4'd2, d1);
    #1;
    chk("wr_wready", 128'(wready_o), 128'(2'b01));
    chk("wr_we", 128'(rf_we_o), 128'(1));
    chk("wr_waddr", 128'(rf_waddr_o), 128'(1));
    chk("wr_wrow", 128'(rf_wrow_o), 128'(0));
    chk("wr_wdata", rf_wdata_o, d1);
    chk("wr_head_t1", 128'(hd(1, 0)), 128'({1'b1, 4'd2, 1'b1, 2'd0}));
    tick(); #1;
    chk("wr_head_t2", 128'(hd(1, 0) >> 7), 128'(0));
    chk("wr_busy_t2", 128'(busy_o), 128'(0));

    // reset during a granted write kills the RF write at once
    tick(); do_push(0, 4'b0010, 4'd3, 1'b1, 2'd0);
    tick(); wr(1, 0, 1, 4'd3, d2);
    #1 chk("rstmid_wready_pre", 128'(wready_o), 128'(2'b10));
    rst_i = 1;
    #1;
    chk("rstmid_we", 128'(rf_we_o), 128'(0));
    chk("rstmid_wready", 128'(wready_o), 128'(0));
    chk("rstmid_busy", 128'(busy_o), 128'(0));
    tick(); rst_i = 0;

    // reads of a token precede its write
    tick(); do_push(2, 4'b0010, 4'd5, 1'b1, 2'd2);
    tick(); wr(1, 2, 1, 4'd5, d3);
    #1 chk("war_wr_first", 128'(wready_o), 128'(0));
    for (int i = 0; i < 2; i++) begin
      tick(); wr(1, 2, 1, 4'd5, d3); rd(0, 2, 1, 4'd5);
      #1;
      chk($sformatf("war_rvalid%0d", i), 128'(rvalid_o), 128'(4'b0001));
      chk($sformatf("war_rdata%0d", i), rdata_o[RL-1:0], pat(3'd2, 2'd1));
      chk($sformatf("war_wready%0d", i), 128'(wready_o), 128'(0));
    end
    tick(); wr(1, 2, 1, 4'd5, d3); rd(0, 2, 1, 4'd5);
    #1;
    chk("war_rd_done", 128'(rvalid_o), 128'(0));
    chk("war_wready", 128'(wready_o), 128'(2'b10));
    chk("war_wdata", rf_wdata_o, d3);
    tick(); #1 chk("war_head_gone", 128'(hd(2, 1) >> 7), 128'(0));

    // four eligible readers, three RF read ports, pointer starts at 0
    do_reset();
    tick(); do_push(3, 4'b1111, 4'd7, 1'b0, 2'd1);
    tick(); for (int p = 0; p < 4; p++) rd(p, 3, p, 4'd7);
    #1;
    chk("rr1_rvalid", 128'(rvalid_o), 128'(4'b0111));
    for (int p = 0; p < 3; p++)
      chk($sformatf("rr1_rdata%0d", p), rdata_o[p*RL +: RL], pat(3'd3, 2'(p)));
    chk("rr1_rrow", 128'(rf_rrow_o), 128'({2'd2, 2'd1, 2'd0}));
    tick(); for (int p = 0; p < 4; p++) rd(p, 3, p, 4'd7);
    #1;
    chk("rr2_rvalid", 128'(rvalid_o), 128'(4'b1000));
    chk("rr2_rdata3", rdata_o[3*RL +: RL], pat(3'd3, 2'd3));
    chk("rr2_rf0", 128'({rf_raddr_o[2:0], rf_rrow_o[1:0]}), 128'({3'd3, 2'd3}));

    // two ports on one head: lower port wins, even when the pointer has moved past it
    tick(); do_push(4, 4'b0001, 4'd1, 1'b0, 2'd2);
    for (int i = 0; i < 2; i++) begin
      tick(); rd(1, 4, 0, 4'd1); rd(2, 4, 0, 4'd1);
      #1 chk($sformatf("samehead%0d", i), 128'(rvalid_o), 128'(4'b0010));
    end

    // pointer now at 2: scan 2,3,0 then 1 next cycle; RF ports filled in ascending port order
    tick(); do_push(3, 4'b1111, 4'd8, 1'b0, 2'd1);
    tick(); for (int p = 0; p < 4; p++) rd(p, 3, p, 4'd8);
    #1;
    chk("rr3_rvalid", 128'(rvalid_o), 128'(4'b1101));
    chk("rr3_rrow", 128'(rf_rrow_o), 128'({2'd3, 2'd2, 2'd0}));
    tick(); for (int p = 0; p < 4; p++) rd(p, 3, p, 4'd8);
    #1;
    chk("rr4_rvalid", 128'(rvalid_o), 128'(4'b0010));
    chk("rr4_rdata1", rdata_o[RL +: RL], pat(3'd3, 2'd1));

    // fill a row to DEPTH, pop+push on full, then a dropped push sets sticky overflow
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tick(); do_push(5, 4'b0100, 4'(i), 1'b1, 2'd0);
    end
    tick(); wr(0, 5, 2, 4'd1, d1); do_push(5, 4'b0100, 4'd6, 1'b1, 2'd0);
    #1;
    chk("fill_full", 128'(full_o), 128'(8'b0010_0000));
    chk("fill_ovf0", 128'(overflow_o), 128'(0));
    chk("fill_wready", 128'(wready_o), 128'(2'b01));
    tick(); do_push(5, 4'b0100, 4'd7, 1'b1, 2'd0);
    #1;
    chk("popush_ovf", 128'(overflow_o), 128'(0));
    chk("popush_full", 128'(full_o), 128'(8'b0010_0000));
    chk("popush_head", 128'(hd(5, 2)), 128'({1'b1, 4'd2, 1'b1, 2'd0}));
    tick(); #1 chk("drop_ovf", 128'(overflow_o), 128'(1));
    tick(); tick(); tick();
    #1 chk("drop_ovf_sticky", 128'(overflow_o), 128'(1));
    for (int i = 0; i < 4; i++) begin
      logic [3:0] ids [4];
      ids = '{4'd2, 4'd3, 4'd4, 4'd6};
      tick(); wr(0, 5, 2, ids[i], d2);
      #1 chk($sformatf("drain%0d", i), 128'(wready_o), 128'(2'b01));
    end
    tick(); #1;
    chk("drain_busy", 128'(busy_o), 128'(0));
    chk("drain_ovf", 128'(overflow_o), 128'(1));
    tick(); flush_i = 1;
    tick(); #1 chk("flush_ovf", 128'(overflow_o), 128'(0));

    // wrong id never granted, head left alone
    tick(); do_push(6, 4'b1000, 4'd3, 1'b0, 2'd1);
    for (int i = 0; i < 10; i++) begin
      tick(); rd(0, 6, 3, 4'd4);
      #1 chk($sformatf("wrongid%0d", i), 128'(rvalid_o), 128'(0));
    end
    chk("wrongid_head", 128'(hd(6, 3)), 128'({1'b1, 4'd3, 1'b0, 2'd1}));

    // flush with three queued tokens, a concurrent write and a concurrent push
    for (int i = 1; i <= 3; i++) begin
      tick(); do_push(7, 4'b0001, 4'(i), 1'b1, 2'd0);
    end
    tick(); flush_i = 1; wr(0, 7, 0, 4'd1, d3); do_push(7, 4'b0001, 4'd4, 1'b1, 2'd0);
    #1;
    chk("flush_wready", 128'(wready_o), 128'(0));
    chk("flush_we", 128'(rf_we_o), 128'(0));
    chk("flush_busy_pre", 128'(busy_o), 128'(1));
    tick(); #1;
    chk("flush_busy", 128'(busy_o), 128'(0));
    chk("flush_head", 128'(head_o), 128'(0));

    // a token expecting nothing is not stored
    tick(); do_push(0, 4'b1111, 4'd9, 1'b0, 2'd0);
    tick(); #1;
    chk("zero_tok_busy", 128'(busy_o), 128'(0));
    chk("zero_tok_ovf", 128'(overflow_o), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
